// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes, control values, alignment FSM states
// and the running-disparity alarm limit.
package tmds_pkg;

  localparam logic [9:0] TOK_CTL0 = 10'b1101010100;
  localparam logic [9:0] TOK_CTL1 = 10'b0010101011;
  localparam logic [9:0] TOK_CTL2 = 10'b0101010100;
  localparam logic [9:0] TOK_CTL3 = 10'b1010101011;

  typedef enum logic [1:0] {
    CTL_00 = 2'd0,
    CTL_01 = 2'd1,
    CTL_10 = 2'd2,
    CTL_11 = 2'd3
  } control_t;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } align_state_t;

  localparam int DISP_LIMIT = 16;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decode: 10-bit word to control token or 8-bit video byte.
module tmds_symbol_decode (
  input  logic [9:0] sym,
  output logic       enable,
  output logic [1:0] control,
  output logic [7:0] data
);
  import tmds_pkg::*;

  logic [7:0] d;

  always_comb begin
    enable  = 1'b0;
    control = CTL_00;
    data    = 8'h00;
    // Undo the optional inversion before unwinding the XOR/XNOR chain.
    d       = sym[9] ? ~sym[7:0] : sym[7:0];
    case (sym)
      TOK_CTL0: control = CTL_00;
      TOK_CTL1: control = CTL_01;
      TOK_CTL2: control = CTL_10;
      TOK_CTL3: control = CTL_11;
      default: begin
        enable    = 1'b1;
        data[0]   = d[0];
        data[7:1] = sym[8] ? (d[7:1] ^ d[6:0]) : ~(d[7:1] ^ d[6:0]);
      end
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: bit-slip word alignment on control tokens plus symbol decode.
// Optional running-disparity checker enabled by defining TMDS_DISPARITY_CHECK_EN.
module tmds_decoder #(
  parameter int LOCK_CNT     = 8,
  parameter int SLIP_WAIT    = 32,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] raw_in,
  input  logic       raw_valid,
  output logic [7:0] data,
  output logic [1:0] control,
  output logic       enable,
  output logic       valid,
  output logic       locked,
  output logic [3:0] offset,
  output logic       disp_err
);
  import tmds_pkg::*;

  localparam int MISS_W = $clog2(SLIP_WAIT);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int IDLE_W = $clog2(LOSS_TIMEOUT);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(SLIP_WAIT - 1);
  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_CNT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOSS_TIMEOUT - 1);

  align_state_t      state, state_nxt;
  logic [3:0]        offset_nxt;
  logic [MISS_W-1:0] miss, miss_nxt;
  logic [RUN_W-1:0]  run, run_nxt;
  logic [IDLE_W-1:0] idle, idle_nxt;
  logic [9:0]        prev_raw;
  logic [19:0]       cat_p0;
  logic [9:0]        window_p0;
  logic              dec_enable;
  logic [1:0]        dec_control;
  logic [7:0]        dec_data;

  // Stage p0: select the 10-bit window from the previous and current words.
  assign cat_p0    = {raw_in, prev_raw};
  assign window_p0 = 10'(cat_p0 >> offset);

  tmds_symbol_decode u_symbol_decode (
    .sym     (window_p0),
    .enable  (dec_enable),
    .control (dec_control),
    .data    (dec_data)
  );

  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    miss_nxt   = miss;
    run_nxt    = run;
    idle_nxt   = idle;
    if (raw_valid) begin
      case (state)
        SEARCH: begin
          if (!dec_enable) begin
            state_nxt = CONFIRM;
            run_nxt   = RUN_W'(1);
            miss_nxt  = '0;
          end else begin
            miss_nxt = miss + 1'b1;
            if (miss_nxt == MISS_LAST) begin
              offset_nxt = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
              miss_nxt   = '0;
            end
          end
        end
        CONFIRM: begin
          if (!dec_enable) begin
            run_nxt = run + 1'b1;
            if (run_nxt == RUN_LOCK) begin
              state_nxt = LOCKED;
              idle_nxt  = '0;
            end
          end else begin
            state_nxt = SEARCH;
            miss_nxt  = '0;
          end
        end
        LOCKED: begin
          if (!dec_enable) begin
            idle_nxt = '0;
          end else begin
            idle_nxt = idle + 1'b1;
            if (idle_nxt == IDLE_LAST) begin
              state_nxt = SEARCH;
              miss_nxt  = '0;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // Stage p1: alignment state and registered decode outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      offset   <= 4'd0;
      miss     <= '0;
      run      <= '0;
      idle     <= '0;
      prev_raw <= 10'd0;
      locked   <= 1'b0;
      valid    <= 1'b0;
      data     <= 8'h00;
      control  <= 2'b00;
      enable   <= 1'b0;
    end else begin
      state  <= state_nxt;
      offset <= offset_nxt;
      miss   <= miss_nxt;
      run    <= run_nxt;
      idle   <= idle_nxt;
      locked <= (state_nxt == LOCKED);
      valid  <= raw_valid && (state == LOCKED);
      if (raw_valid) begin
        prev_raw <= raw_in;
        data     <= dec_data;
        control  <= dec_control;
        enable   <= dec_enable;
      end
    end
  end

`ifdef TMDS_DISPARITY_CHECK_EN
  localparam logic signed [6:0] DISP_LIM = 7'(DISP_LIMIT);

  function automatic logic disp_over_limit(input logic signed [6:0] v);
    return (v > DISP_LIM) || (v < -DISP_LIM);
  endfunction

  logic signed [6:0] disp, disp_upd;
  logic [3:0]        ones;

  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 10; i++) ones = ones + {3'd0, window_p0[i]};
    disp_upd = disp + $signed({2'b00, ones, 1'b0}) - 7'sd10;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp     <= '0;
      disp_err <= 1'b0;
    end else begin
      disp_err <= 1'b0;
      if (raw_valid) begin
        if (!dec_enable) begin
          disp <= '0;
        end else if (state == LOCKED) begin
          if (disp_over_limit(disp_upd)) begin
            disp_err <= 1'b1;
            disp     <= '0;
          end else begin
            disp <= disp_upd;
          end
          if (state_nxt != LOCKED) disp <= '0;
        end
      end
    end
  end
`else
  assign disp_err = 1'b0;
`endif

endmodule
